// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) definitions: widths, parity placement, syndrome and payload helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hamming_pkg;

  localparam int CW_W  = 21;
  localparam int D_W   = 16;
  localparam int SYN_W = 5;

  // Parity bits sit at codeword indices 0,1,3,7,15 (Hamming positions 1,2,4,8,16).
  localparam logic [CW_W-1:0] PAR_MASK = 21'h00808B;

  // XOR of the 1-based positions of all set bits. Zero for a valid codeword.
  // The encoder uses the same function over a parity-cleared word to derive parity.
  function automatic logic [SYN_W-1:0] calcSyndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (cw[i]) s ^= SYN_W'(i + 1);
    end
    return s;
  endfunction

  // Packs the non-parity bits, lowest index first, into the payload.
  function automatic logic [D_W-1:0] extractPayload(input logic [CW_W-1:0] cw);
    logic [D_W-1:0] d;
    int             j;
    d = '0;
    j = 0;
    for (int i = 0; i < CW_W; i++) begin
      if (!PAR_MASK[i]) begin
        d[j[3:0]] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational 21->5 Hamming syndrome.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: codeword (21-bit input), syndrome (5-bit output, 0 = clean).
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  codeword,
  output logic [SYN_W-1:0] syndrome
);

  assign syndrome = calcSyndrome(codeword);

endmodule

// File: rtl/hamming_dec.sv
// SEC decoder for Hamming(21,16) codewords with saturating error statistics.
// Latency: 2 cycles from upstream accept to oValid; 1 word/cycle throughput.
// Backpressure: 2-stage stallable pipeline; oReady falls only when both stages hold a word and iReady=0.
// Ports: clk/rst; upstream iData/iValid/oReady; downstream oData/oValid/iReady with
//        oErrCorr/oErrUncorr qualifiers; iClrCnt clears oCorrCnt/oUncorrCnt.
module hamming_dec
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CW_W  = 21,
  parameter int D_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW_W-1:0]  iData,
  input  logic             iValid,
  output logic             oReady,
  output logic [D_W-1:0]   oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oErrCorr,
  output logic             oErrUncorr,
  input  logic             iClrCnt,
  output logic [CNT_W-1:0] oCorrCnt,
  output logic [CNT_W-1:0] oUncorrCnt
);

  // The codeword map is hard-wired; refuse to build any other geometry.
  if (CW_W != hamming_pkg::CW_W || D_W != hamming_pkg::D_W) begin : gBadGeometry
    $error("hamming_dec supports only CW_W=21, D_W=16");
  end

  logic             en1, en2;
  logic             v1, v2;
  logic [CW_W-1:0]  cw1, fixedCw;
  logic [SYN_W-1:0] syn, syn1;
  logic             isCorr, isUncorr;
  logic [D_W-1:0]   data2;
  logic             corr2, uncorr2;
  logic             outXfer;
  logic [CNT_W-1:0] corrCnt, uncorrCnt;

  hamming_syndrome uSyndrome (
    .codeword (iData),
    .syndrome (syn)
  );

  assign en2    = !v2 || iReady;
  assign en1    = !v1 || en2;
  assign oReady = en1;

  // Syndromes 1..21 name the bad position; 22..31 point past the codeword.
  assign isCorr   = (syn1 != '0) && (syn1 <= SYN_W'(CW_W));
  assign isUncorr = (syn1 >  SYN_W'(CW_W));

  // Flip the bit the syndrome points at; out-of-range syndromes match nothing.
  always_comb begin
    fixedCw = cw1;
    for (int i = 0; i < CW_W; i++) begin
      fixedCw[i] = cw1[i] ^ (syn1 == SYN_W'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      cw1  <= '0;
      syn1 <= '0;
    end else if (en1) begin
      v1   <= iValid;
      cw1  <= iData;
      syn1 <= syn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      data2   <= '0;
      corr2   <= 1'b0;
      uncorr2 <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        data2   <= extractPayload(fixedCw);
        corr2   <= isCorr;
        uncorr2 <= isUncorr;
      end else begin
        data2   <= '0;
        corr2   <= 1'b0;
        uncorr2 <= 1'b0;
      end
    end
  end

  // Statistics count delivered words, so a stalled word is counted once.
  assign outXfer = v2 && iReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corrCnt   <= '0;
      uncorrCnt <= '0;
    end else if (iClrCnt) begin
      corrCnt   <= '0;
      uncorrCnt <= '0;
    end else begin
      if (outXfer && corr2 && (corrCnt != '1))
        corrCnt <= corrCnt + CNT_W'(1);
      if (outXfer && uncorr2 && (uncorrCnt != '1))
        uncorrCnt <= uncorrCnt + CNT_W'(1);
    end
  end

  assign oValid     = v2;
  assign oData      = data2;
  assign oErrCorr   = corr2;
  assign oErrUncorr = uncorr2;
  assign oCorrCnt   = corrCnt;
  assign oUncorrCnt = uncorrCnt;

endmodule

// File: tb/tb_hamming_dec.sv
// Directed testbench for hamming_dec (counters built 4 bits wide to reach saturation quickly).
module tb_hamming_dec;

  logic        clk;
  logic        rst;
  logic [20:0] iData;
  logic        iValid;
  logic        oReady;
  logic [15:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oErrCorr;
  logic        oErrUncorr;
  logic        iClrCnt;
  logic [3:0]  oCorrCnt;
  logic [3:0]  oUncorrCnt;

  int nChecks = 0;
  int nFail   = 0;

  hamming_dec #(.CNT_W(4), .CW_W(21), .D_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .iData      (iData),
    .iValid     (iValid),
    .oReady     (oReady),
    .oData      (oData),
    .oValid     (oValid),
    .iReady     (iReady),
    .oErrCorr   (oErrCorr),
    .oErrUncorr (oErrUncorr),
    .iClrCnt    (iClrCnt),
    .oCorrCnt   (oCorrCnt),
    .oUncorrCnt (oUncorrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: place payload, then set each parity bit that zeroes its syndrome bit.
  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] cw;
    logic [4:0]  s;
    cw        = '0;
    cw[2]     = d[0];
    cw[6:4]   = d[3:1];
    cw[14:8]  = d[10:4];
    cw[20:16] = d[15:11];
    s = '0;
    for (int i = 0; i < 21; i++) if (cw[i]) s ^= 5'(i + 1);
    for (int k = 0; k < 5; k++) if (s[k]) cw[(1 << k) - 1] = 1'b1;
    return cw;
  endfunction

  // Sends one word with iReady=1 and returns the decoded result; lat=-1 on timeout.
  // Returns one cycle after the downstream transfer so counters are already updated.
  task automatic runWord(input logic [20:0] cw, output logic [15:0] d,
                         output logic c, output logic u, output int lat);
    iReady = 1'b1;
    iData  = cw;
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    iData  = '0;
    lat = -1;
    d = '0; c = 1'b0; u = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (oValid) begin
        lat = k;
        d = oData; c = oErrCorr; u = oErrUncorr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic clrCnt();
    iClrCnt = 1'b1;
    @(posedge clk); #1;
    iClrCnt = 1'b0;
  endtask

  task automatic test_reset();
    nChecks++; if (oValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    nChecks++; if (oData !== 16'h0) begin nFail++; $display("FAIL reset_data: got %h expected 0000", oData); end
    nChecks++; if ({oErrCorr, oErrUncorr} !== 2'b00) begin nFail++; $display("FAIL reset_flags: got %b expected 00", {oErrCorr, oErrUncorr}); end
    nChecks++; if ({oCorrCnt, oUncorrCnt} !== 8'h00) begin nFail++; $display("FAIL reset_cnt: got %h expected 00", {oCorrCnt, oUncorrCnt}); end
    rst = 1'b0;
    @(posedge clk); #1;
    nChecks++; if (oReady !== 1'b1) begin nFail++; $display("FAIL reset_ready: got %b expected 1", oReady); end
  endtask

  task automatic test_clean();
    logic [15:0] d; logic c, u; int lat;
    runWord(21'h1FFFFE, d, c, u, lat);
    nChecks++; if (lat !== 2) begin nFail++; $display("FAIL clean_latency: got %0d expected 2", lat); end
    nChecks++; if (d !== 16'hFFFF) begin nFail++; $display("FAIL clean_data: got %h expected ffff", d); end
    nChecks++; if ({c, u} !== 2'b00) begin nFail++; $display("FAIL clean_flags: got %b expected 00", {c, u}); end
    nChecks++; if ({oCorrCnt, oUncorrCnt} !== 8'h00) begin nFail++; $display("FAIL clean_cnt: got %h expected 00", {oCorrCnt, oUncorrCnt}); end
  endtask

  task automatic test_single_errors();
    logic [15:0] d; logic c, u; int lat;
    runWord(21'h000020, d, c, u, lat);
    nChecks++; if (d !== 16'h0000) begin nFail++; $display("FAIL single_bit5_data: got %h expected 0000", d); end
    nChecks++; if ({c, u} !== 2'b10) begin nFail++; $display("FAIL single_bit5_flags: got %b expected 10", {c, u}); end
    nChecks++; if (oCorrCnt !== 4'd1) begin nFail++; $display("FAIL single_bit5_cnt: got %0d expected 1", oCorrCnt); end
    clrCnt();
    nChecks++; if (oCorrCnt !== 4'd0) begin nFail++; $display("FAIL single_clr: got %0d expected 0", oCorrCnt); end
    for (int i = 0; i < 21; i++) begin
      runWord(21'h1FFFFE ^ (21'd1 << i), d, c, u, lat);
      nChecks++;
      if (d !== 16'hFFFF || c !== 1'b1 || u !== 1'b0) begin
        nFail++;
        $display("FAIL single_flip_%0d: got data %h corr %b uncorr %b expected ffff 1 0", i, d, c, u);
      end
    end
    nChecks++; if (oCorrCnt !== 4'hF) begin nFail++; $display("FAIL single_cnt_sat: got %0d expected 15", oCorrCnt); end
    nChecks++; if (oUncorrCnt !== 4'h0) begin nFail++; $display("FAIL single_uncorr_cnt: got %0d expected 0", oUncorrCnt); end
  endtask

  task automatic test_double_errors();
    logic [15:0] d; logic c, u; int lat;
    clrCnt();
    runWord(21'h100400, d, c, u, lat);
    nChecks++; if (d !== 16'h8040) begin nFail++; $display("FAIL uncorr_data: got %h expected 8040", d); end
    nChecks++; if ({c, u} !== 2'b01) begin nFail++; $display("FAIL uncorr_flags: got %b expected 01", {c, u}); end
    nChecks++; if (oUncorrCnt !== 4'd1) begin nFail++; $display("FAIL uncorr_cnt: got %0d expected 1", oUncorrCnt); end
    runWord(21'h000003, d, c, u, lat);
    nChecks++; if (d !== 16'h0001) begin nFail++; $display("FAIL miscorr_data: got %h expected 0001", d); end
    nChecks++; if ({c, u} !== 2'b10) begin nFail++; $display("FAIL miscorr_flags: got %b expected 10", {c, u}); end
    nChecks++; if (oCorrCnt !== 4'd1) begin nFail++; $display("FAIL miscorr_cnt: got %0d expected 1", oCorrCnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pay [5];
    logic [20:0] cws [5];
    int acc, del;
    bit sawDrop, stalledPrev;
    logic [15:0] held;
    pay[0] = 16'h1234; pay[1] = 16'hABCD; pay[2] = 16'h0F0F; pay[3] = 16'hFFFF; pay[4] = 16'h0001;
    for (int i = 0; i < 5; i++) cws[i] = encode(pay[i]);
    cws[2] = cws[2] ^ 21'h000200;   // one corrected word inside the stream
    acc = 0; del = 0; sawDrop = 0; stalledPrev = 0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      iReady = !(cyc >= 4 && cyc < 8);
      iValid = (acc < 5);
      iData  = (acc < 5) ? cws[acc] : 21'h0;
      #1;
      if (oValid && iReady) begin
        nChecks++;
        if (oData !== pay[del]) begin nFail++; $display("FAIL stream_word_%0d: got %h expected %h", del, oData, pay[del]); end
        del++;
      end
      if (oValid && !iReady) begin
        if (stalledPrev) begin
          nChecks++;
          if (oData !== held) begin nFail++; $display("FAIL stall_hold: got %h expected %h", oData, held); end
        end
        held = oData;
        stalledPrev = 1;
      end else begin
        stalledPrev = 0;
      end
      if (!oReady && !sawDrop) begin
        sawDrop = 1;
        nChecks++;
        if (acc - del !== 2) begin nFail++; $display("FAIL stall_buffered: got %0d expected 2", acc - del); end
      end
      if (iValid && oReady) acc++;
      @(posedge clk); #1;
      if (del == 5) break;
    end
    iValid = 1'b0;
    iReady = 1'b1;
    nChecks++; if (del !== 5) begin nFail++; $display("FAIL stream_count: got %0d expected 5", del); end
    nChecks++; if (sawDrop !== 1'b1) begin nFail++; $display("FAIL stall_ready_drop: got %b expected 1", sawDrop); end
  endtask

  task automatic test_saturation();
    logic [15:0] d; logic c, u; int lat;
    clrCnt();
    for (int k = 1; k <= 17; k++) begin
      runWord(21'h000020, d, c, u, lat);
      if (k == 14) begin
        nChecks++; if (oCorrCnt !== 4'd14) begin nFail++; $display("FAIL sat_cnt_14: got %0d expected 14", oCorrCnt); end
      end
    end
    nChecks++; if (oCorrCnt !== 4'hF) begin nFail++; $display("FAIL sat_cnt_17: got %0d expected 15", oCorrCnt); end
    // Clear coinciding with a corrected downstream transfer.
    iReady = 1'b1;
    iData  = 21'h000020;
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    @(posedge clk); #1;
    nChecks++; if ({oValid, oErrCorr} !== 2'b11) begin nFail++; $display("FAIL clr_coincide_setup: got %b expected 11", {oValid, oErrCorr}); end
    iClrCnt = 1'b1;
    @(posedge clk); #1;
    iClrCnt = 1'b0;
    nChecks++; if (oCorrCnt !== 4'd0) begin nFail++; $display("FAIL clr_priority: got %0d expected 0", oCorrCnt); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d; logic c, u; int lat;
    runWord(21'h000020, d, c, u, lat);
    nChecks++; if (oCorrCnt !== 4'd1) begin nFail++; $display("FAIL arst_pre_cnt: got %0d expected 1", oCorrCnt); end
    iReady = 1'b0;
    iValid = 1'b1;
    iData  = encode(16'h5555);
    @(posedge clk); #1;
    iData  = encode(16'hAAAA);
    @(posedge clk); #1;
    iValid = 1'b0;
    nChecks++; if (oValid !== 1'b1) begin nFail++; $display("FAIL arst_pre_valid: got %b expected 1", oValid); end
    #2;
    rst = 1'b1;
    #1;
    nChecks++; if (oValid !== 1'b0) begin nFail++; $display("FAIL arst_valid: got %b expected 0", oValid); end
    nChecks++; if (oData !== 16'h0) begin nFail++; $display("FAIL arst_data: got %h expected 0000", oData); end
    nChecks++; if (oCorrCnt !== 4'd0) begin nFail++; $display("FAIL arst_cnt: got %0d expected 0", oCorrCnt); end
    #3;
    rst = 1'b0;
    iReady = 1'b1;
    @(posedge clk); #1;
    nChecks++; if (oReady !== 1'b1) begin nFail++; $display("FAIL arst_ready: got %b expected 1", oReady); end
    @(posedge clk); #1;
    nChecks++; if (oValid !== 1'b0) begin nFail++; $display("FAIL arst_no_partial: got %b expected 0", oValid); end
    runWord(encode(16'hC3A5), d, c, u, lat);
    nChecks++; if (lat !== 2) begin nFail++; $display("FAIL arst_next_latency: got %0d expected 2", lat); end
    nChecks++; if (d !== 16'hC3A5) begin nFail++; $display("FAIL arst_next_data: got %h expected c3a5", d); end
    nChecks++; if ({c, u} !== 2'b00) begin nFail++; $display("FAIL arst_next_flags: got %b expected 00", {c, u}); end
  endtask

  initial begin
    rst     = 1'b1;
    iValid  = 1'b0;
    iData   = '0;
    iReady  = 1'b0;
    iClrCnt = 1'b0;
    #12;
    test_reset();
    test_clean();
    test_single_errors();
    test_double_errors();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
